// File: rtl/bus_arbiter_rr.sv
// Round-robin serial system-bus arbiter and 1-bit interconnect (N masters, M slaves); optional slave-ready timeout under ARB_TIMEOUT_EN.
// Latency: grant 1 cycle after request, slave select SLAVE_ADDR_W cycles after grant, zero-cycle data path while in DATA.
// Backpressure: the owner sees the selected slave's s_ready on m_ready; decode errors (and timeouts) answer with m_ready=1 until release.
module bus_arbiter_rr #(
    parameter int MASTER_COUNT = 2,
    parameter int SLAVE_ADDR_W = 2,
    parameter int SLAVE_COUNT  = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MASTER_COUNT-1:0]   m_breq,
    input  logic [MASTER_COUNT-1:0]   m_addr,
    input  logic [MASTER_COUNT-1:0]   m_wdata,
    input  logic [MASTER_COUNT-1:0]   m_write,
    output logic [MASTER_COUNT-1:0]   m_grant,
    output logic [MASTER_COUNT-1:0]   m_rdata,
    output logic [MASTER_COUNT-1:0]   m_ready,
    output logic [2*MASTER_COUNT-1:0] m_resp,
    input  logic [SLAVE_COUNT-1:0]    s_rdata,
    input  logic [SLAVE_COUNT-1:0]    s_ready,
    output logic [SLAVE_COUNT-1:0]    s_select,
    output logic [SLAVE_COUNT-1:0]    s_wdata,
    output logic [SLAVE_COUNT-1:0]    s_write
);

    // Pointer and bit-counter widths; a single master or a 1-bit address
    // still gets a 1-bit register so every vector stays legal.
    localparam int PTR_W = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int CNT_W = (SLAVE_ADDR_W > 1) ? $clog2(SLAVE_ADDR_W) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t                    state_q, state_d;
    logic [MASTER_COUNT-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [SLAVE_ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [SLAVE_COUNT-1:0]    sel_q, sel_d;
    logic [1:0]                resp_q, resp_d;

`ifdef ARB_TIMEOUT_EN
    // Counter only has to reach TIMEOUT-1; the cycle that would make it
    // TIMEOUT is the one that fires the error instead.
    localparam int         TMO_W        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] RESP_TIMEOUT = 2'b10;

    logic [TMO_W-1:0]          tmo_q, tmo_d;
`endif

    // Owner-side and selected-slave-side bits. The grant and select
    // registers are one-hot, so AND-OR reduction picks the single
    // relevant bit without needing an owner index register.
    logic                      own_breq;
    logic                      own_addr;
    logic                      own_wdata;
    logic                      own_write;
    logic                      sel_ready;
    logic                      sel_rdata;

    assign own_breq  = |(grant_q & m_breq);
    assign own_addr  = |(grant_q & m_addr);
    assign own_wdata = |(grant_q & m_wdata);
    assign own_write = |(grant_q & m_write);
    assign sel_ready = |(sel_q & s_ready);
    assign sel_rdata = |(sel_q & s_rdata);

    // Round-robin search: first requester found walking circularly from
    // the master after the last one granted.
    logic                      rr_found;
    logic [PTR_W-1:0]          rr_pick;
    logic [MASTER_COUNT-1:0]   rr_grant;
    int                        rr_idx;

    // Find the winning master for the next grant.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_idx   = 0;
        for (int k = 0; k < MASTER_COUNT; k++) begin
            rr_idx = (int'(ptr_q) + 1 + k) % MASTER_COUNT;
            if (!rr_found && m_breq[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = PTR_W'(rr_idx);
            end
        end
    end

    // Expand the winner index into the one-hot grant vector.
    always_comb begin
        rr_grant = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            rr_grant[i] = (PTR_W'(i) == rr_pick);
        end
    end

    // Address register after this cycle's bit is shifted in (MSB first),
    // and its decode into a one-hot select.
    logic [SLAVE_ADDR_W-1:0]   addr_shift;
    logic                      dec_hit;
    logic [SLAVE_COUNT-1:0]    dec_sel;

    assign addr_shift = SLAVE_ADDR_W'({addr_q, own_addr});
    assign dec_hit    = (int'(addr_shift) < SLAVE_COUNT);

    // Decode the completed address into a slave select.
    always_comb begin
        dec_sel = '0;
        for (int s = 0; s < SLAVE_COUNT; s++) begin
            dec_sel[s] = (int'(addr_shift) == s);
        end
    end

    // Next-state and next-register values for the bus FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        resp_d  = resp_q;
`ifdef ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    state_d = ADDR;
                    grant_d = rr_grant;
                    ptr_d   = rr_pick;
                    addr_d  = '0;
                    cnt_d   = '0;
                    sel_d   = '0;
                    resp_d  = RESP_OKAY;
`ifdef ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ADDR: begin
                if (!own_breq) begin
                    // Abort before any slave has been selected.
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    resp_d  = RESP_OKAY;
                end else begin
                    addr_d = addr_shift;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SLAVE_ADDR_W - 1)) begin
                        cnt_d = '0;
                        if (dec_hit) begin
                            state_d = DATA;
                            sel_d   = dec_sel;
                        end else begin
                            state_d = ERR;
                            resp_d  = RESP_DECERR;
                        end
                    end
                end
            end
            DATA: begin
                if (!own_breq) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    resp_d  = RESP_OKAY;
`ifdef ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // Consecutive not-ready cycles; any ready cycle restarts the count.
                    if (sel_ready) begin
                        tmo_d = '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_d = ERR;
                        resp_d  = RESP_TIMEOUT;
                        sel_d   = '0;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
`endif
                end
            end
            ERR: begin
                if (!own_breq) begin
                    state_d = IDLE;
                    grant_d = '0;
                    sel_d   = '0;
                    resp_d  = RESP_OKAY;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                sel_d   = '0;
                resp_d  = RESP_OKAY;
            end
        endcase
    end

    // State and datapath registers; reset leaves master 0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(MASTER_COUNT - 1);
            addr_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            resp_q  <= RESP_OKAY;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            resp_q  <= resp_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign m_grant  = grant_q;
    assign s_select = sel_q;

    // Owner-facing outputs: routed slave data in DATA, forced ready plus
    // held response in ERR, zero for everyone else.
    always_comb begin
        m_rdata = '0;
        m_ready = '0;
        m_resp  = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            m_rdata[i] = grant_q[i] & (state_q == DATA) & sel_rdata;
            m_ready[i] = grant_q[i] & (((state_q == DATA) & sel_ready) | (state_q == ERR));
            m_resp[2*i +: 2] = (grant_q[i] && (state_q == ERR)) ? resp_q : RESP_OKAY;
        end
    end

    // Slave-facing outputs: only the selected slave sees the owner's bits.
    always_comb begin
        s_wdata = '0;
        s_write = '0;
        for (int s = 0; s < SLAVE_COUNT; s++) begin
            s_wdata[s] = sel_q[s] & (state_q == DATA) & own_wdata;
            s_write[s] = sel_q[s] & (state_q == DATA) & own_write;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: 2 masters, 2-bit address, 3 slaves, TIMEOUT=4.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Combinational paths are checked 1 time unit after their inputs change.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] m_breq;
    logic [1:0] m_addr;
    logic [1:0] m_wdata;
    logic [1:0] m_write;
    logic [1:0] m_grant;
    logic [1:0] m_rdata;
    logic [1:0] m_ready;
    logic [3:0] m_resp;
    logic [2:0] s_rdata;
    logic [2:0] s_ready;
    logic [2:0] s_select;
    logic [2:0] s_wdata;
    logic [2:0] s_write;

    int n_cmp = 0;
    int n_err = 0;

    bus_arbiter_rr #(
        .MASTER_COUNT (2),
        .SLAVE_ADDR_W (2),
        .SLAVE_COUNT  (3),
        .TIMEOUT      (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_breq   (m_breq),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_write  (m_write),
        .m_grant  (m_grant),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_resp   (m_resp),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .s_select (s_select),
        .s_wdata  (s_wdata),
        .s_write  (s_write)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One round-robin transaction by master m to slave 1 (address 2'b01).
    // Entered just after the grant edge; leaves in IDLE with m_breq[m] re-raised.
    task automatic rr_txn(input int m);
        logic [1:0] own;
        own = 2'b00;
        own[m] = 1'b1;
        chk("rr_grant", m_grant, own);
        m_addr = 2'b00;
        tick();
        m_addr[m] = 1'b1;
        tick();
        chk("rr_select", s_select, 3'b010);
        s_ready = 3'b010;
        s_rdata = 3'b010;
        #1;
        chk("rr_ready", m_ready, own);
        chk("rr_rdata", m_rdata, own);
        tick();
        tick();
        chk("rr_select_hold", s_select, 3'b010);
        m_breq[m] = 1'b0;
        tick();
        chk("rr_idle_grant", m_grant, 2'b00);
        chk("rr_idle_select", s_select, 3'b000);
        m_breq[m] = 1'b1;
        m_addr  = 2'b00;
        s_ready = 3'b000;
        s_rdata = 3'b000;
    endtask

    initial begin
        reset   = 1'b1;
        m_breq  = 2'b11;
        m_addr  = 2'b00;
        m_wdata = 2'b00;
        m_write = 2'b00;
        s_rdata = 3'b000;
        s_ready = 3'b000;

        // Reset with both masters requesting.
        tick();
        tick();
        chk("rst_grant", m_grant, 2'b00);
        chk("rst_select", s_select, 3'b000);
        chk("rst_ready", m_ready, 2'b00);
        chk("rst_resp", m_resp, 4'b0000);
        chk("rst_rdata", m_rdata, 2'b00);
        chk("rst_wdata", s_wdata, 3'b000);
        chk("rst_write", s_write, 3'b000);
        reset = 1'b0;

        // Round-robin with both requests held: 0,1,0,1.
        tick();
        rr_txn(0);
        tick();
        rr_txn(1);
        tick();
        rr_txn(0);
        tick();
        rr_txn(1);

        // Data routing: master 1 writes to slave 2 then reads back.
        m_breq = 2'b10;
        tick();
        chk("wr_grant", m_grant, 2'b10);
        m_addr[1] = 1'b1;
        tick();
        chk("wr_addr_select", s_select, 3'b000);
        m_addr[1]  = 1'b0;
        m_write[1] = 1'b1;
        m_wdata[1] = 1'b1;
        tick();
        chk("wr_select", s_select, 3'b100);
        chk("wr_wdata_1", s_wdata, 3'b100);
        chk("wr_write", s_write, 3'b100);
        m_wdata[1] = 1'b0;
        #1;
        chk("wr_wdata_0", s_wdata, 3'b000);
        chk("wr_write_hold", s_write, 3'b100);
        tick();
        m_wdata[1] = 1'b1;
        #1;
        chk("wr_wdata_1b", s_wdata, 3'b100);
        m_write[1] = 1'b0;
        m_wdata[1] = 1'b0;
        s_rdata = 3'b110;
        s_ready = 3'b100;
        #1;
        chk("rd_rdata", m_rdata, 2'b10);
        chk("rd_ready", m_ready, 2'b10);
        chk("rd_write", s_write, 3'b000);
        chk("rd_resp", m_resp, 4'b0000);
        m_breq  = 2'b00;
        s_rdata = 3'b000;
        s_ready = 3'b000;
        tick();
        chk("wr_release", m_grant, 2'b00);

        // Decode error: master 0 sends 2'b11.
        m_breq = 2'b01;
        tick();
        chk("de_grant", m_grant, 2'b01);
        m_addr = 2'b01;
        tick();
        tick();
        chk("de_resp", m_resp, 4'b0001);
        chk("de_ready", m_ready, 2'b01);
        chk("de_select", s_select, 3'b000);
        tick();
        tick();
        chk("de_resp_hold", m_resp, 4'b0001);
        chk("de_ready_hold", m_ready, 2'b01);
        m_breq = 2'b00;
        m_addr = 2'b00;
        tick();
        chk("de_release_resp", m_resp, 4'b0000);
        chk("de_release_ready", m_ready, 2'b00);
        chk("de_release_grant", m_grant, 2'b00);

        // Abort: master 1 drops after one address bit, master 0 pending.
        m_breq = 2'b11;
        tick();
        chk("ab_grant", m_grant, 2'b10);
        tick();
        m_breq = 2'b01;
        tick();
        chk("ab_idle_grant", m_grant, 2'b00);
        chk("ab_idle_select", s_select, 3'b000);
        tick();
        chk("ab_pending_grant", m_grant, 2'b01);
        chk("ab_pending_select", s_select, 3'b000);

        // Master 0 to slave 0 with s_ready held low.
        tick();
        tick();
        chk("to_select", s_select, 3'b001);
`ifdef ARB_TIMEOUT_EN
        tick();
        tick();
        tick();
        chk("to_not_yet_resp", m_resp, 4'b0000);
        chk("to_not_yet_select", s_select, 3'b001);
        tick();
        chk("to_resp", m_resp, 4'b0010);
        chk("to_select_drop", s_select, 3'b000);
        chk("to_ready", m_ready, 2'b01);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
        end
        chk("hold_grant", m_grant, 2'b01);
        chk("hold_select", s_select, 3'b001);
        chk("hold_resp", m_resp, 4'b0000);
        chk("hold_ready", m_ready, 2'b00);
`endif
        m_breq = 2'b00;
        tick();
        chk("to_release_grant", m_grant, 2'b00);
        chk("to_release_resp", m_resp, 4'b0000);

        // Reset mid-transaction re-initialises the pointer.
        m_breq = 2'b01;
        tick();
        chk("mr_grant", m_grant, 2'b01);
        tick();
        reset  = 1'b1;
        m_breq = 2'b11;
        tick();
        chk("mr_rst_grant", m_grant, 2'b00);
        chk("mr_rst_select", s_select, 3'b000);
        chk("mr_rst_ready", m_ready, 2'b00);
        chk("mr_rst_resp", m_resp, 4'b0000);
        reset = 1'b0;
        tick();
        chk("mr_first_grant", m_grant, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
